// File: rtl/display_pkg.sv
// Shared display-path definitions: layer indices, game state codes
// and the per-state layer masks the game FSM loads after reset.
package display_pkg;

   localparam int L_INTERFACE = 0;
   localparam int L_PLAYER    = 1;
   localparam int L_BOSS      = 2;
   localparam int L_OBJ       = 3;
   localparam int L_MAP       = 4;
   localparam int L_DOOR      = 5;

   typedef enum logic [3:0] {
      ST_TITLE    = 4'd0,
      ST_MENU     = 4'd1,
      ST_STAGE1   = 4'd2,
      ST_STAGE2   = 4'd3,
      ST_STAGE3   = 4'd4,
      ST_BOSS     = 4'd5,
      ST_GAMEOVER = 4'd6,
      ST_WIN      = 4'd7,
      ST_PAUSE    = 4'd8,
      ST_HELP     = 4'd9
   } game_state_e;

   localparam logic [7:0] MASK_TITLE = 8'b0000_0011;
   localparam logic [7:0] MASK_TEXT  = 8'b0000_0001;
   localparam logic [7:0] MASK_STAGE = 8'b1111_1111;

   function automatic logic [7:0] default_mask(game_state_e s);
      logic [7:0] m;
      m = MASK_TEXT;
      unique case (s)
         ST_TITLE:  m = MASK_TITLE;
         ST_STAGE1,
         ST_STAGE2,
         ST_STAGE3,
         ST_BOSS:   m = MASK_STAGE;
         default:   m = MASK_TEXT;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder with found flag.
module prio_enc
   import display_pkg::*;
#(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          found
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = i[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage layer priority compositor with per-state masks,
// frame-based blinking and per-frame collision reporting.
module layer_compositor
   import display_pkg::*;
#(
   parameter int N_LAYERS = 8,
   parameter int ADDR_W   = 17,
   parameter int STATE_W  = 4,
   parameter int N_STATES = 16,
   parameter int BLINK_W  = 4,
   parameter int COLL_REF = L_PLAYER
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         de,
   input  logic                         frame_start,
   input  logic [STATE_W-1:0]           state,
   input  logic [N_LAYERS-1:0]          layer_hit,
   input  logic [N_LAYERS*ADDR_W-1:0]   layer_addr,
   input  logic [N_LAYERS-1:0]          blink_en,
   input  logic                         cfg_we,
   input  logic [STATE_W-1:0]           cfg_state,
   input  logic [N_LAYERS-1:0]          cfg_mask,
   output logic [ADDR_W-1:0]            pixel_addr,
   output logic                         notBlank,
   output logic [$clog2(N_LAYERS)-1:0]  layer_sel,
   output logic [N_LAYERS-1:0]          coll_vec,
   output logic                         coll_valid
);

   localparam int SEL_W = $clog2(N_LAYERS);
   localparam int DEPTH = 2 ** STATE_W;

   logic [N_LAYERS-1:0]        mask_tbl [DEPTH];
   logic [DEPTH-1:0]           st_ok;
   logic [N_LAYERS-1:0]        mask;
   logic [N_LAYERS-1:0]        vis;
   logic [BLINK_W-1:0]         blink_cnt;
   logic [N_LAYERS-1:0]        q_hit;
   logic [N_LAYERS*ADDR_W-1:0] q_addr;
   logic [N_LAYERS-1:0]        acc;
   logic [N_LAYERS-1:0]        coll_c;
   logic [SEL_W-1:0]           win_idx;
   logic                       win_found;
   logic [ADDR_W-1:0]          win_addr;

   // Table is sized to the full state code space; codes past N_STATES
   // read as an all-zero mask and are never written.
   always_comb begin
      for (int s = 0; s < DEPTH; s++) begin
         st_ok[s] = (s < N_STATES);
      end
   end

   always_comb begin
      mask = st_ok[state] ? mask_tbl[state] : '0;
      vis  = ~blink_en | {N_LAYERS{~blink_cnt[BLINK_W-1]}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < DEPTH; s++) begin
            mask_tbl[s] <= '1;
         end
      end else if (cfg_we && st_ok[cfg_state]) begin
         mask_tbl[cfg_state] <= cfg_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
      end else if (frame_start) begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_hit  <= '0;
         q_addr <= '0;
      end else begin
         q_hit  <= layer_hit & mask & vis & {N_LAYERS{de}};
         q_addr <= layer_addr;
      end
   end

   prio_enc #(
      .N  (N_LAYERS),
      .IW (SEL_W)
   ) u_prio (
      .req   (q_hit),
      .idx   (win_idx),
      .found (win_found)
   );

   always_comb begin
      win_addr = q_addr[int'(win_idx)*ADDR_W +: ADDR_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pixel_addr <= '0;
         layer_sel  <= '0;
         notBlank   <= 1'b0;
      end else begin
         pixel_addr <= win_found ? win_addr : '0;
         layer_sel  <= win_found ? win_idx : '0;
         notBlank   <= win_found;
      end
   end

   always_comb begin
      coll_c           = q_hit & {N_LAYERS{q_hit[COLL_REF]}};
      coll_c[COLL_REF] = 1'b0;
   end

   // A drawn overlap coinciding with frame_start opens the new frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         coll_vec   <= '0;
         coll_valid <= 1'b0;
      end else if (frame_start) begin
         acc        <= coll_c;
         coll_vec   <= acc;
         coll_valid <= 1'b1;
      end else begin
         acc        <= acc | coll_c;
         coll_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed scenarios plus
// randomized traffic against a frame-level reference model.
module tb_layer_compositor;

   localparam int NL = 8;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst;
   logic          de;
   logic          frame_start;
   logic [3:0]    state;
   logic [NL-1:0] layer_hit;
   logic [NL*AW-1:0] layer_addr;
   logic [NL-1:0] blink_en;
   logic          cfg_we;
   logic [3:0]    cfg_state;
   logic [NL-1:0] cfg_mask;
   logic [AW-1:0] pixel_addr;
   logic          notBlank;
   logic [2:0]    layer_sel;
   logic [NL-1:0] coll_vec;
   logic          coll_valid;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [NL-1:0] mask_m [16];
   int            fcount;
   logic [NL-1:0] s1_vis;
   logic [AW-1:0] s1_addr, m_addr;
   logic [2:0]    s1_sel, m_sel;
   logic          s1_nb, m_nb;
   logic [NL-1:0] acc_m, cv_m;
   logic          cval_m;

   layer_compositor dut (
      .clk         (clk),
      .rst         (rst),
      .de          (de),
      .frame_start (frame_start),
      .state       (state),
      .layer_hit   (layer_hit),
      .layer_addr  (layer_addr),
      .blink_en    (blink_en),
      .cfg_we      (cfg_we),
      .cfg_state   (cfg_state),
      .cfg_mask    (cfg_mask),
      .pixel_addr  (pixel_addr),
      .notBlank    (notBlank),
      .layer_sel   (layer_sel),
      .coll_vec    (coll_vec),
      .coll_valid  (coll_valid)
   );

   always #5 clk = ~clk;

   task automatic idle();
      rst         = 1'b0;
      de          = 1'b0;
      frame_start = 1'b0;
      layer_hit   = '0;
      cfg_we      = 1'b0;
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      layer_addr[i*AW +: AW] = a;
   endtask

   // Advance one clock; the model computes what the current inputs
   // mean, then tracks where that pixel is after the edge.
   task automatic step();
      logic [NL-1:0] eff, contrib;
      logic [AW-1:0] p_addr;
      logic [2:0]    p_sel;
      logic          p_nb, on;
      eff = '0;
      for (int i = 0; i < NL; i++) begin
         on = !blink_en[i] || ((fcount % 16) < 8);
         if (de && layer_hit[i] && mask_m[state][i] && on) eff[i] = 1'b1;
      end
      p_nb = 1'b0; p_sel = '0; p_addr = '0;
      for (int i = 0; i < NL; i++) begin
         if (eff[i] && !p_nb) begin
            p_nb   = 1'b1;
            p_sel  = 3'(i);
            p_addr = layer_addr[i*AW +: AW];
         end
      end
      contrib = s1_vis[1] ? s1_vis : '0;
      contrib[1] = 1'b0;
      @(posedge clk);
      #1;
      if (rst) begin
         m_addr = '0; m_sel = '0; m_nb = 1'b0;
         s1_addr = '0; s1_sel = '0; s1_nb = 1'b0; s1_vis = '0;
         acc_m = '0; cv_m = '0; cval_m = 1'b0;
         fcount = 0;
         for (int s = 0; s < 16; s++) mask_m[s] = '1;
      end else begin
         m_addr = s1_addr; m_sel = s1_sel; m_nb = s1_nb;
         s1_addr = p_addr; s1_sel = p_sel; s1_nb = p_nb; s1_vis = eff;
         if (frame_start) begin
            cv_m   = acc_m;
            cval_m = 1'b1;
            acc_m  = contrib;
            fcount++;
         end else begin
            acc_m  = acc_m | contrib;
            cval_m = 1'b0;
         end
         if (cfg_we) mask_m[cfg_state] = cfg_mask;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; de = 1'b1; frame_start = 1'b1;
      layer_hit = 8'hFF; cfg_we = 1'b0;
      step();
      n_cmp++; if (pixel_addr !== '0) begin n_err++;
         $display("FAIL reset pixel_addr got %h want 0", pixel_addr); end
      n_cmp++; if (notBlank !== 1'b0) begin n_err++;
         $display("FAIL reset notBlank got %b want 0", notBlank); end
      n_cmp++; if (layer_sel !== '0) begin n_err++;
         $display("FAIL reset layer_sel got %0d want 0", layer_sel); end
      n_cmp++; if (coll_vec !== '0) begin n_err++;
         $display("FAIL reset coll_vec got %b want 0", coll_vec); end
      n_cmp++; if (coll_valid !== 1'b0) begin n_err++;
         $display("FAIL reset coll_valid got %b want 0", coll_valid); end
      idle();
   endtask

   task automatic test_priority();
      idle();
      blink_en = '0; state = 4'd2;
      set_addr(2, 17'h100); set_addr(4, 17'h200);
      de = 1'b1; layer_hit = 8'b0011_0100;
      step();
      idle(); step();
      n_cmp++; if (pixel_addr !== 17'h100) begin n_err++;
         $display("FAIL prio addr got %h want 100", pixel_addr); end
      n_cmp++; if (layer_sel !== 3'd2) begin n_err++;
         $display("FAIL prio sel got %0d want 2", layer_sel); end
      n_cmp++; if (notBlank !== 1'b1) begin n_err++;
         $display("FAIL prio notBlank got %b want 1", notBlank); end
      de = 1'b0; layer_hit = 8'b0011_0100;
      step();
      idle(); step();
      n_cmp++; if (notBlank !== 1'b0 || pixel_addr !== '0) begin n_err++;
         $display("FAIL prio_de0 got nb=%b addr=%h want 0/0",
                  notBlank, pixel_addr); end
   endtask

   task automatic test_mask_write();
      idle();
      state = 4'd2; de = 1'b1; layer_hit = 8'b0011_0100;
      cfg_we = 1'b1; cfg_state = 4'd2; cfg_mask = 8'b1111_1011;
      step();
      cfg_we = 1'b0;
      step();
      n_cmp++; if (pixel_addr !== 17'h100) begin n_err++;
         $display("FAIL mask_old addr got %h want 100", pixel_addr); end
      idle(); step();
      n_cmp++; if (pixel_addr !== 17'h200 || layer_sel !== 3'd4) begin
         n_err++;
         $display("FAIL mask_new got addr=%h sel=%0d want 200/4",
                  pixel_addr, layer_sel); end
      cfg_we = 1'b1; cfg_mask = 8'hFF; step();
      idle();
   endtask

   task automatic test_blink();
      logic want;
      rst = 1'b1; step(); idle();
      blink_en = 8'b0000_0100; state = 4'd2; set_addr(2, 17'h0ABC);
      for (int k = 0; k <= 16; k++) begin
         de = 1'b1; layer_hit = 8'b0000_0100;
         step();
         idle(); step();
         want = ((k % 16) < 8);
         n_cmp++; if (notBlank !== want) begin n_err++;
            $display("FAIL blink frame %0d notBlank got %b want %b",
                     k, notBlank, want); end
         frame_start = 1'b1; step(); frame_start = 1'b0;
      end
      blink_en = '0;
   endtask

   task automatic test_collision();
      idle(); blink_en = '0; state = 4'd2;
      step();
      frame_start = 1'b1; step(); frame_start = 1'b0;
      de = 1'b1; layer_hit = 8'b0000_1010; step();
      idle(); step(); step(); step();
      frame_start = 1'b1; step(); frame_start = 1'b0;
      n_cmp++; if (coll_vec !== 8'b0000_1000 || coll_valid !== 1'b1) begin
         n_err++;
         $display("FAIL coll_hit got vec=%b valid=%b want 00001000/1",
                  coll_vec, coll_valid); end
      step();
      n_cmp++; if (coll_valid !== 1'b0 || coll_vec !== 8'b0000_1000) begin
         n_err++;
         $display("FAIL coll_pulse got vec=%b valid=%b want 00001000/0",
                  coll_vec, coll_valid); end
      step();
      frame_start = 1'b1; step(); frame_start = 1'b0;
      n_cmp++; if (coll_vec !== '0 || coll_valid !== 1'b1) begin n_err++;
         $display("FAIL coll_clear got vec=%b valid=%b want 0/1",
                  coll_vec, coll_valid); end
      step();
   endtask

   task automatic test_boundary();
      idle(); state = 4'd2; blink_en = '0;
      step();
      frame_start = 1'b1; step(); frame_start = 1'b0;
      step();
      de = 1'b1; layer_hit = 8'b0010_0010; step();
      idle(); frame_start = 1'b1; step();
      n_cmp++; if (coll_vec !== '0 || coll_valid !== 1'b1) begin n_err++;
         $display("FAIL boundary_cur got vec=%b valid=%b want 0/1",
                  coll_vec, coll_valid); end
      step();
      n_cmp++; if (coll_vec !== 8'b0010_0000 || coll_valid !== 1'b1) begin
         n_err++;
         $display("FAIL boundary_next got vec=%b valid=%b want 00100000/1",
                  coll_vec, coll_valid); end
      frame_start = 1'b0; step();
      n_cmp++; if (coll_valid !== 1'b0) begin n_err++;
         $display("FAIL boundary_end valid got %b want 0", coll_valid); end
   endtask

   task automatic test_reset_midframe();
      idle(); blink_en = '0;
      cfg_we = 1'b1; cfg_state = 4'd2; cfg_mask = '0; step();
      cfg_state = 4'd15; step(); cfg_we = 1'b0;
      state = 4'd3; de = 1'b1; layer_hit = 8'b0000_1010;
      set_addr(1, 17'h1_2345); step(); step();
      rst = 1'b1; step();
      n_cmp++; if (notBlank !== 1'b0 || pixel_addr !== '0 ||
                   layer_sel !== '0 || coll_vec !== '0 ||
                   coll_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid got nb=%b addr=%h sel=%0d cv=%b v=%b want 0",
                  notBlank, pixel_addr, layer_sel, coll_vec, coll_valid); end
      rst = 1'b0; state = 4'd2; de = 1'b1; layer_hit = 8'b0000_0100;
      set_addr(2, 17'h0_0777); step();
      n_cmp++; if (notBlank !== 1'b0) begin n_err++;
         $display("FAIL rst_flush notBlank got %b want 0", notBlank); end
      idle(); step();
      n_cmp++; if (notBlank !== 1'b1 || pixel_addr !== 17'h0_0777) begin
         n_err++;
         $display("FAIL rst_mask got nb=%b addr=%h want 1/00777",
                  notBlank, pixel_addr); end
      cfg_we = 1'b1; cfg_state = 4'd15; cfg_mask = '0; step();
      cfg_we = 1'b0; state = 4'd15; de = 1'b1; layer_hit = 8'hFF; step();
      idle(); step();
      n_cmp++; if (notBlank !== 1'b0) begin n_err++;
         $display("FAIL state15_masked notBlank got %b want 0", notBlank); end
   endtask

   task automatic test_random();
      rst = 1'b1; step(); idle();
      for (int c = 0; c < 600; c++) begin
         rst         = ($urandom_range(0, 249) == 0);
         de          = ($urandom_range(0, 3) != 0);
         frame_start = ($urandom_range(0, 15) == 0);
         state       = 4'($urandom_range(0, 15));
         layer_hit   = 8'($urandom);
         blink_en    = 8'($urandom);
         for (int i = 0; i < NL; i++) set_addr(i, 17'($urandom));
         cfg_we      = ($urandom_range(0, 7) == 0);
         cfg_state   = 4'($urandom_range(0, 15));
         cfg_mask    = 8'($urandom);
         step();
         n_cmp++; if (pixel_addr !== m_addr || layer_sel !== m_sel ||
                      notBlank !== m_nb) begin
            n_err++;
            $display("FAIL rand_pix c=%0d got %h/%0d/%b want %h/%0d/%b",
                     c, pixel_addr, layer_sel, notBlank,
                     m_addr, m_sel, m_nb); end
         n_cmp++; if (coll_vec !== cv_m || coll_valid !== cval_m) begin
            n_err++;
            $display("FAIL rand_coll c=%0d got %b/%b want %b/%b",
                     c, coll_vec, coll_valid, cv_m, cval_m); end
      end
      idle();
   endtask

   initial begin
      fcount = 0; acc_m = '0; cv_m = '0; cval_m = 1'b0; s1_vis = '0;
      s1_addr = '0; s1_sel = '0; s1_nb = 1'b0;
      m_addr = '0; m_sel = '0; m_nb = 1'b0;
      for (int s = 0; s < 16; s++) mask_m[s] = '1;
      layer_addr = '0; blink_en = '0; state = '0;
      cfg_state = '0; cfg_mask = '0;
      idle();
      test_reset();
      test_priority();
      test_mask_write();
      test_blink();
      test_collision();
      test_boundary();
      test_reset_midframe();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
